sprite_draw_arbiter: RTL and testbench



---
 rtl/sprite_draw_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sprite_draw_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_arbiter.sv
// ---------------------------------------------------------------------------
// sprite_draw_arbiter : round-robin owner of the framebuffer write port;
//   scans the owner's sprite box and emits one pixel slot per cycle.
//   Optional: SPRITE_DRAW_ARBITER_TRANSPARENT_EN (key-colour suppression).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sprite_draw_arbiter #(
  parameter int         NUM_REQ            = 2,
  parameter logic [2:0] BG_COLOUR          = 3'b000,
  parameter int         SCREEN_W           = 320,
  parameter int         SCREEN_H           = 240,
  parameter logic [2:0] TRANSPARENT_COLOUR = 3'b101
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   erase,
  input  logic [NUM_REQ*9-1:0] box_x,
  input  logic [NUM_REQ*8-1:0] box_y,
  input  logic [NUM_REQ*6-1:0] box_w,
  input  logic [NUM_REQ*6-1:0] box_h,
  input  logic [NUM_REQ*3-1:0] sprite_colour,
  output logic [5:0]           x_off,
  output logic [5:0]           y_off,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 plot,
  output logic [8:0]           x,
  output logic [7:0]           y,
  output logic [2:0]           colour,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy
);

  localparam int             IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [9:0]     SCR_W    = 10'(SCREEN_W);
  localparam logic [8:0]     SCR_H    = 9'(SCREEN_H);
`ifdef SPRITE_DRAW_ARBITER_TRANSPARENT_EN
  localparam bit             TRANSP_EN = 1'b1;
`else
  localparam bit             TRANSP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [8:0] bx_a [NUM_REQ];
  logic [7:0] by_a [NUM_REQ];
  logic [5:0] bw_a [NUM_REQ];
  logic [5:0] bh_a [NUM_REQ];
  logic [2:0] sc_a [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign bx_a[gi] = box_x[9*gi +: 9];
      assign by_a[gi] = box_y[8*gi +: 8];
      assign bw_a[gi] = box_w[6*gi +: 6];
      assign bh_a[gi] = box_h[6*gi +: 6];
      assign sc_a[gi] = sprite_colour[3*gi +: 3];
    end
  endgenerate

  logic [IW-1:0]      rr, owner, win;
  logic               found;
  logic [IW:0]        sum;
  logic [8:0]         bx;
  logic [7:0]         by;
  logic [5:0]         bw, bh;
  logic               er;
  logic               last;
  logic [9:0]         xs;
  logic [8:0]         ys;
  logic [2:0]         sc_owner;
  logic               key_hit;
  logic [NUM_REQ-1:0] win_onehot;

  // Search starts at the round-robin pointer and wraps modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  assign win_onehot = NUM_REQ'(1) << win;
  assign last       = (x_off == bw) && (y_off == bh);
  assign xs         = {1'b0, bx} + {4'b0, x_off};
  assign ys         = {1'b0, by} + {3'b0, y_off};
  assign sc_owner   = sc_a[owner];
  assign key_hit    = TRANSP_EN && !er && (sc_owner == TRANSPARENT_COLOUR);
  assign busy       = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = SCAN;
      SCAN:    if (last)  state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rr     <= '0;
      owner  <= '0;
      grant  <= '0;
      bx     <= '0;
      by     <= '0;
      bw     <= '0;
      bh     <= '0;
      er     <= 1'b0;
      x_off  <= '0;
      y_off  <= '0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      done   <= '0;
    end else begin
      plot <= 1'b0;
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            bx    <= bx_a[win];
            by    <= by_a[win];
            bw    <= bw_a[win];
            bh    <= bh_a[win];
            er    <= erase[win];
            owner <= win;
            grant <= win_onehot;
            rr    <= (win == LAST_IDX) ? '0 : win + 1'b1;
            x_off <= '0;
            y_off <= '0;
          end
        end
        SCAN: begin
          // Clip against the full-width sums so off-screen pixels never wrap.
          x      <= xs[8:0];
          y      <= ys[7:0];
          colour <= er ? BG_COLOUR : sc_owner;
          plot   <= (xs < SCR_W) && (ys < SCR_H) && !key_hit;
          if (x_off == bw) begin
            x_off <= '0;
            y_off <= y_off + 6'd1;
          end else begin
            x_off <= x_off + 6'd1;
          end
          if (last) done <= grant;
        end
        FLUSH: grant <= '0;
        default: grant <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sprite_draw_arbiter : directed stimulus with a queue-based pixel/done
//   scoreboard for sprite_draw_arbiter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sprite_draw_arbiter;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  req, erase;
  logic [17:0] box_x;
  logic [15:0] box_y;
  logic [11:0] box_w, box_h;
  logic [5:0]  sprite_colour;
  logic [5:0]  x_off, y_off;
  logic [1:0]  grant, done;
  logic        plot, busy;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;

  logic [2:0]  sc0, sc1;
  logic        alt;

  // Requester 0 can act as a ROM whose data alternates with the column offset.
  assign sprite_colour = {sc1, alt ? (x_off[0] ? 3'b011 : 3'b101) : sc0};

  sprite_draw_arbiter dut (
    .clock(clock), .resetn(resetn), .req(req), .erase(erase),
    .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
    .sprite_colour(sprite_colour), .x_off(x_off), .y_off(y_off),
    .grant(grant), .plot(plot), .x(x), .y(y), .colour(colour),
    .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         cyc;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;
  typedef struct {
    int         cyc;
    logic [1:0] d;
  } done_t;

  pix_t  pq[$];
  done_t dq[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_pix(input int c, input int px, input int py, input logic [2:0] col);
    pix_t p;
    p.cyc = c; p.x = 9'(px); p.y = 8'(py); p.c = col;
    pq.push_back(p);
  endtask

  task automatic exp_done(input int c, input logic [1:0] d);
    done_t e;
    e.cyc = c; e.d = d;
    dq.push_back(e);
  endtask

  task automatic set_box(input int i, input int bx, input int by, input int w, input int h);
    box_x[9*i +: 9] = 9'(bx);
    box_y[8*i +: 8] = 8'(by);
    box_w[6*i +: 6] = 6'(w);
    box_h[6*i +: 6] = 6'(h);
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step;
  endtask

  // Monitor: every plot and done pulse is matched against the queues.
  always @(negedge clock) begin : monitor
    pix_t  p;
    done_t e;
    if (plot) begin
      if (pq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0d expected none (cycle %0d)",
                 x, y, colour, cyc);
      end else begin
        p = pq.pop_front();
        check("plot_cycle", cyc, p.cyc);
        check("plot_x", int'(x), int'(p.x));
        check("plot_y", int'(y), int'(p.y));
        check("plot_colour", int'(colour), int'(p.c));
      end
    end
    if (done != 2'b00) begin
      if (dq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got %0d expected none (cycle %0d)", done, cyc);
      end else begin
        e = dq.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("done_value", int'(done), int'(e.d));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    resetn = 1'b0; req = '0; erase = '0;
    box_x = '0; box_y = '0; box_w = '0; box_h = '0;
    sc0 = '0; sc1 = '0; alt = 1'b0;

    step;
    check("rst_grant", int'(grant), 0);
    check("rst_plot", int'(plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_xoff", int'(x_off), 0);
    resetn = 1'b1;
    step;

    // 2x2 box, constant colour
    t = cyc;
    set_box(0, 10, 20, 1, 1); sc0 = 3'b010; req = 2'b01;
    exp_pix(t+2, 10, 20, 3'b010); exp_pix(t+3, 11, 20, 3'b010);
    exp_pix(t+4, 10, 21, 3'b010); exp_pix(t+5, 11, 21, 3'b010);
    exp_done(t+5, 2'b01);
    step_to(t+1);
    check("t1_grant", int'(grant), 1);
    check("t1_busy", int'(busy), 1);
    req = 2'b00;
    step_to(t+5);
    check("t1_busy_last", int'(busy), 1);
    step_to(t+6);
    check("t1_idle_busy", int'(busy), 0);
    check("t1_idle_grant", int'(grant), 0);

    // fresh reset so round robin starts at requester 0
    resetn = 1'b0; step; resetn = 1'b1; step;
    t = cyc;
    set_box(0, 50, 60, 0, 0); set_box(1, 70, 80, 0, 0);
    sc0 = 3'b001; sc1 = 3'b110; req = 2'b11;
    exp_pix(t+2, 50, 60, 3'b001);  exp_done(t+2, 2'b01);
    exp_pix(t+5, 70, 80, 3'b110);  exp_done(t+5, 2'b10);
    exp_pix(t+8, 50, 60, 3'b001);  exp_done(t+8, 2'b01);
    exp_pix(t+11, 70, 80, 3'b110); exp_done(t+11, 2'b10);
    step_to(t+1);  check("rr_grant0", int'(grant), 1);
    step_to(t+3);  check("rr_gap0", int'(grant), 0); check("rr_gap0_busy", int'(busy), 0);
    step_to(t+4);  check("rr_grant1", int'(grant), 2);
    step_to(t+6);  check("rr_gap1", int'(grant), 0);
    step_to(t+7);  check("rr_grant2", int'(grant), 1);
    step_to(t+9);  check("rr_gap2", int'(grant), 0);
    step_to(t+10); check("rr_grant3", int'(grant), 2);
    req = 2'b00;
    step_to(t+12); check("rr_idle", int'(busy), 0);

    // right-edge clip: 4 slots, only x=318,319 plotted
    t = cyc;
    set_box(0, 318, 5, 3, 0); sc0 = 3'b011; req = 2'b01;
    exp_pix(t+2, 318, 5, 3'b011); exp_pix(t+3, 319, 5, 3'b011);
    exp_done(t+5, 2'b01);
    step_to(t+1); req = 2'b00;
    step_to(t+6); check("clipx_idle", int'(busy), 0);

    // bottom-edge clip on requester 1
    t = cyc;
    set_box(1, 100, 238, 0, 2); sc1 = 3'b100; req = 2'b10;
    exp_pix(t+2, 100, 238, 3'b100); exp_pix(t+3, 100, 239, 3'b100);
    exp_done(t+4, 2'b10);
    step_to(t+1); check("clipy_grant", int'(grant), 2); req = 2'b00;
    step_to(t+5); check("clipy_idle", int'(busy), 0);

    // sums past 511 must clip, not wrap to small x
    t = cyc;
    set_box(0, 500, 10, 15, 0); req = 2'b01;
    exp_done(t+17, 2'b01);
    step_to(t+1); req = 2'b00;
    step_to(t+18); check("wrap_idle", int'(busy), 0);

    // erase mode; mid-scan box/erase changes are ignored
    t = cyc;
    set_box(0, 5, 6, 1, 0); erase = 2'b01; sc0 = 3'b111; req = 2'b01;
    exp_pix(t+2, 5, 6, 3'b000); exp_pix(t+3, 6, 6, 3'b000);
    exp_done(t+3, 2'b01);
    step_to(t+1); req = 2'b00; set_box(0, 200, 100, 5, 5); erase = 2'b00;
    step_to(t+4); check("erase_idle", int'(busy), 0);

    // reset during the third scan cycle
    t = cyc;
    set_box(0, 0, 0, 3, 3); sc0 = 3'b010; req = 2'b01;
    exp_pix(t+2, 0, 0, 3'b010); exp_pix(t+3, 1, 0, 3'b010);
    step_to(t+3); resetn = 1'b0;
    step_to(t+4);
    check("abort_plot", int'(plot), 0);
    check("abort_grant", int'(grant), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    resetn = 1'b1; set_box(0, 30, 31, 0, 0);
    exp_pix(t+6, 30, 31, 3'b010); exp_done(t+6, 2'b01);
    step_to(t+5); check("regrant", int'(grant), 1); req = 2'b00;
    step_to(t+7); check("regrant_idle", int'(busy), 0);

    // colour alternating 101/011 by column
    t = cyc;
    alt = 1'b1; set_box(0, 40, 40, 3, 0); req = 2'b01;
`ifdef SPRITE_DRAW_ARBITER_TRANSPARENT_EN
    exp_pix(t+3, 41, 40, 3'b011); exp_pix(t+5, 43, 40, 3'b011);
`else
    exp_pix(t+2, 40, 40, 3'b101); exp_pix(t+3, 41, 40, 3'b011);
    exp_pix(t+4, 42, 40, 3'b101); exp_pix(t+5, 43, 40, 3'b011);
`endif
    exp_done(t+5, 2'b01);
    step_to(t+1); req = 2'b00;
    step_to(t+6); check("alt_idle", int'(busy), 0);
    alt = 1'b0;

    step; step;
    check("pix_queue_empty", pq.size(), 0);
    check("done_queue_empty", dq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
